// File: rtl/cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : cpu_prog_loader
// Purpose  : Stream-driven program loader for the axis_cpu. Consumes a 32-bit
//            AXI-Stream of section headers and payload words and unpacks them
//            into single-entry write strobes for the instruction memory, the
//            immediates table and the jump-offset table. Holds the CPU idle
//            (loading) during a load and pulses done on an END header.
// Ports    : clk, rst (async, active-low)
//            prog_TDATA/TVALID/TREADY/TLAST - program stream in
//            inst_mem_wr_addr/data/en      - instruction byte writes
//            imm_wr_addr/data/en           - immediate table writes
//            jmp_off_wr_addr/data/en       - jump offset table writes
//            loading, done, err            - load status
// Revision : 1.0 - initial release
// ============================================================================
module cpu_prog_loader #(
    // Must not exceed 10: the header address field is 10 bits wide.
    parameter int CODE_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                prog_TDATA,
    input  logic                       prog_TVALID,
    output logic                       prog_TREADY,
    input  logic                       prog_TLAST,
    output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
    output logic [7:0]                 inst_mem_wr_data,
    output logic                       inst_mem_wr_en,
    output logic [3:0]                 imm_wr_addr,
    output logic [31:0]                imm_wr_data,
    output logic                       imm_wr_en,
    output logic [3:0]                 jmp_off_wr_addr,
    output logic [7:0]                 jmp_off_wr_data,
    output logic                       jmp_off_wr_en,
    output logic                       loading,
    output logic                       done,
    output logic                       err
);

    localparam logic [1:0] c_TYPE_INST = 2'b00;
    localparam logic [1:0] c_TYPE_IMM  = 2'b01;
    localparam logic [1:0] c_TYPE_JMP  = 2'b10;
    localparam logic [1:0] c_TYPE_END  = 2'b11;

    localparam logic [CODE_ADDR_WIDTH-1:0] c_ADDR_ONE = CODE_ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_HDR    = 3'd0,
        S_INST_W = 3'd1,
        S_UNPACK = 3'd2,
        S_IMM_W  = 3'd3,
        S_JMP_W  = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t                     r_state;
    logic                       r_tready;
    logic [CODE_ADDR_WIDTH-1:0] r_inst_addr;
    logic [7:0]                 r_inst_data;
    logic                       r_inst_en;
    logic [3:0]                 r_imm_addr;
    logic [31:0]                r_imm_data;
    logic                       r_imm_en;
    logic [3:0]                 r_jmp_addr;
    logic [7:0]                 r_jmp_data;
    logic                       r_jmp_en;
    logic                       r_loading;
    logic                       r_done;
    logic                       r_err;

    // Section working registers: next write address, items still to write,
    // the upper three bytes of the current word and how many of them the
    // UNPACK state has already emitted.
    logic [CODE_ADDR_WIDTH-1:0] r_addr;
    logic [15:0]                r_remain;
    logic [23:0]                r_word;
    logic [1:0]                 r_idx;
    logic                       r_abort;
    logic                       r_is_jmp;

    logic                       w_accept;
    logic [1:0]                 w_hdr_type;
    logic [15:0]                w_hdr_count;
    logic [16:0]                w_range_end;
    logic                       w_range_bad;
    logic                       w_byte_early;
    logic                       w_unused_bits;

    assign w_accept    = prog_TVALID & r_tready;
    assign w_hdr_type  = prog_TDATA[31:30];
    assign w_hdr_count = prog_TDATA[15:0];
    // 17-bit sum so a large count cannot wrap past the table-size check.
    assign w_range_end = {13'd0, prog_TDATA[19:16]} + {1'b0, prog_TDATA[15:0]};
    assign w_range_bad = (w_range_end > 17'd16);
    // A byte-section word holds up to four items; TLAST is premature when
    // more than four items are still outstanding.
    assign w_byte_early  = prog_TLAST & (r_remain > 16'd4);
    assign w_unused_bits = &{1'b0, prog_TDATA[29:26]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_HDR;
            r_tready    <= 1'b0;
            r_inst_addr <= '0;
            r_inst_data <= '0;
            r_inst_en   <= 1'b0;
            r_imm_addr  <= '0;
            r_imm_data  <= '0;
            r_imm_en    <= 1'b0;
            r_jmp_addr  <= '0;
            r_jmp_data  <= '0;
            r_jmp_en    <= 1'b0;
            r_loading   <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= '0;
            r_remain    <= '0;
            r_word      <= '0;
            r_idx       <= '0;
            r_abort     <= 1'b0;
            r_is_jmp    <= 1'b0;
        end else begin
            // Strobes and done are single-cycle; TREADY is high in every
            // state except UNPACK, and branches entering UNPACK override it.
            r_inst_en <= 1'b0;
            r_imm_en  <= 1'b0;
            r_jmp_en  <= 1'b0;
            r_done    <= 1'b0;
            r_tready  <= 1'b1;

            case (r_state)
                S_HDR: begin
                    if (w_accept) begin
                        r_err    <= 1'b0;
                        r_abort  <= 1'b0;
                        r_remain <= w_hdr_count;
                        r_is_jmp <= (w_hdr_type == c_TYPE_JMP);
                        if (w_hdr_type == c_TYPE_INST) begin
                            r_addr <= prog_TDATA[16 +: CODE_ADDR_WIDTH];
                        end else begin
                            r_addr <= {{(CODE_ADDR_WIDTH-4){1'b0}}, prog_TDATA[19:16]};
                        end
                        if (w_hdr_type == c_TYPE_END) begin
                            r_done    <= 1'b1;
                            r_loading <= 1'b0;
                            r_state   <= S_HDR;
                        end else begin
                            r_loading <= 1'b1;
                            if (w_hdr_count == 16'd0) begin
                                r_state <= S_HDR;
                            end else if ((w_hdr_type != c_TYPE_INST) && w_range_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_DRAIN;
                            end else if (w_hdr_type == c_TYPE_INST) begin
                                r_state <= S_INST_W;
                            end else if (w_hdr_type == c_TYPE_IMM) begin
                                r_state <= S_IMM_W;
                            end else begin
                                r_state <= S_JMP_W;
                            end
                        end
                    end
                end

                S_INST_W, S_JMP_W: begin
                    if (w_accept) begin
                        if (r_is_jmp) begin
                            r_jmp_en   <= 1'b1;
                            r_jmp_addr <= r_addr[3:0];
                            r_jmp_data <= prog_TDATA[7:0];
                        end else begin
                            r_inst_en   <= 1'b1;
                            r_inst_addr <= r_addr;
                            r_inst_data <= prog_TDATA[7:0];
                        end
                        r_addr   <= r_addr + c_ADDR_ONE;
                        r_remain <= r_remain - 16'd1;
                        r_word   <= prog_TDATA[31:8];
                        r_idx    <= 2'd0;
                        // Remember a premature TLAST so UNPACK finishes this
                        // word and then falls back to header parsing.
                        r_abort  <= w_byte_early;
                        if (w_byte_early) begin
                            r_err <= 1'b1;
                        end
                        if (r_remain > 16'd1) begin
                            r_state  <= S_UNPACK;
                            r_tready <= 1'b0;
                        end else begin
                            r_state <= S_HDR;
                        end
                    end
                end

                S_UNPACK: begin
                    if (r_is_jmp) begin
                        r_jmp_en   <= 1'b1;
                        r_jmp_addr <= r_addr[3:0];
                        r_jmp_data <= r_word[7:0];
                    end else begin
                        r_inst_en   <= 1'b1;
                        r_inst_addr <= r_addr;
                        r_inst_data <= r_word[7:0];
                    end
                    r_addr   <= r_addr + c_ADDR_ONE;
                    r_remain <= r_remain - 16'd1;
                    r_word   <= {8'h00, r_word[23:8]};
                    // Word exhausted after its fourth byte or the section's
                    // last item, whichever comes first.
                    if ((r_idx == 2'd2) || (r_remain == 16'd1)) begin
                        if ((r_remain != 16'd1) && !r_abort) begin
                            r_state <= r_is_jmp ? S_JMP_W : S_INST_W;
                        end else begin
                            r_state <= S_HDR;
                        end
                    end else begin
                        r_idx    <= r_idx + 2'd1;
                        r_tready <= 1'b0;
                    end
                end

                S_IMM_W: begin
                    if (w_accept) begin
                        r_imm_en   <= 1'b1;
                        r_imm_addr <= r_addr[3:0];
                        r_imm_data <= prog_TDATA;
                        r_addr     <= r_addr + c_ADDR_ONE;
                        r_remain   <= r_remain - 16'd1;
                        if (r_remain == 16'd1) begin
                            r_state <= S_HDR;
                        end else if (prog_TLAST) begin
                            r_err   <= 1'b1;
                            r_state <= S_HDR;
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_accept && prog_TLAST) begin
                        r_state <= S_HDR;
                    end
                end

                default: begin
                    r_state <= S_HDR;
                end
            endcase
        end
    end

    assign prog_TREADY      = r_tready;
    assign inst_mem_wr_addr = r_inst_addr;
    assign inst_mem_wr_data = r_inst_data;
    assign inst_mem_wr_en   = r_inst_en;
    assign imm_wr_addr      = r_imm_addr;
    assign imm_wr_data      = r_imm_data;
    assign imm_wr_en        = r_imm_en;
    assign jmp_off_wr_addr  = r_jmp_addr;
    assign jmp_off_wr_data  = r_jmp_data;
    assign jmp_off_wr_en    = r_jmp_en;
    assign loading          = r_loading;
    assign done             = r_done;
    assign err              = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cpu_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_prog_loader
// Purpose  : Self-checking bench for cpu_prog_loader. Writes observed on the
//            three strobe ports are collected by a monitor and compared with
//            a section-level reference model built from the header rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_prog_loader;

    localparam int CAW = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [31:0]    prog_TDATA  = '0;
    logic           prog_TVALID = 1'b0;
    logic           prog_TLAST  = 1'b0;
    logic           prog_TREADY;
    logic [CAW-1:0] inst_mem_wr_addr;
    logic [7:0]     inst_mem_wr_data;
    logic           inst_mem_wr_en;
    logic [3:0]     imm_wr_addr;
    logic [31:0]    imm_wr_data;
    logic           imm_wr_en;
    logic [3:0]     jmp_off_wr_addr;
    logic [7:0]     jmp_off_wr_data;
    logic           jmp_off_wr_en;
    logic           loading;
    logic           done;
    logic           err;

    always #5 clk = ~clk;

    cpu_prog_loader #(.CODE_ADDR_WIDTH(CAW)) dut (
        .clk              (clk),
        .rst              (rst),
        .prog_TDATA       (prog_TDATA),
        .prog_TVALID      (prog_TVALID),
        .prog_TREADY      (prog_TREADY),
        .prog_TLAST       (prog_TLAST),
        .inst_mem_wr_addr (inst_mem_wr_addr),
        .inst_mem_wr_data (inst_mem_wr_data),
        .inst_mem_wr_en   (inst_mem_wr_en),
        .imm_wr_addr      (imm_wr_addr),
        .imm_wr_data      (imm_wr_data),
        .imm_wr_en        (imm_wr_en),
        .jmp_off_wr_addr  (jmp_off_wr_addr),
        .jmp_off_wr_data  (jmp_off_wr_data),
        .jmp_off_wr_en    (jmp_off_wr_en),
        .loading          (loading),
        .done             (done),
        .err              (err)
    );

    // kind: 0 instruction, 1 immediate, 2 jump (same as header type codes)
    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t obs_q[$];
    wr_t exp_q[$];
    wr_t mon_e;

    int n_checks   = 0;
    int n_fail     = 0;
    int cyc        = 0;
    int tready_low = 0;
    int done_cnt   = 0;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (!prog_TREADY) tready_low++;
            if (done) begin
                done_cnt++;
                n_checks++;
                if (loading !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_loading_same_cycle: loading=%b while done high, required 0", loading);
                end
            end
            n_checks++;
            if (int'(inst_mem_wr_en) + int'(imm_wr_en) + int'(jmp_off_wr_en) > 1) begin
                n_fail++;
                $display("FAIL strobe_exclusive: inst=%b imm=%b jmp=%b, required at most one high",
                         inst_mem_wr_en, imm_wr_en, jmp_off_wr_en);
            end
            if (inst_mem_wr_en) begin
                mon_e.kind = 0; mon_e.addr = int'(inst_mem_wr_addr);
                mon_e.data = {24'h0, inst_mem_wr_data}; mon_e.cyc = cyc;
                obs_q.push_back(mon_e);
            end
            if (imm_wr_en) begin
                mon_e.kind = 1; mon_e.addr = int'(imm_wr_addr);
                mon_e.data = imm_wr_data; mon_e.cyc = cyc;
                obs_q.push_back(mon_e);
            end
            if (jmp_off_wr_en) begin
                mon_e.kind = 2; mon_e.addr = int'(jmp_off_wr_addr);
                mon_e.data = {24'h0, jmp_off_wr_data}; mon_e.cyc = cyc;
                obs_q.push_back(mon_e);
            end
        end
    end

    function automatic logic [31:0] hdr(input int t, input int s, input int n);
        logic [31:0] v;
        v = {t[1:0], 4'b0000, s[9:0], n[15:0]};
        return v;
    endfunction

    task automatic push_exp(input int kind, input int addr, input logic [31:0] data);
        wr_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.cyc = 0;
        exp_q.push_back(e);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [31:0] d, input logic l, input int idle);
        int g;
        prog_TVALID = 1'b0;
        repeat (idle) @(negedge clk);
        prog_TDATA  = d;
        prog_TLAST  = l;
        prog_TVALID = 1'b1;
        g = 0;
        while (prog_TREADY !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: TREADY=%b after 50 cycles, required 1", prog_TREADY);
        end
        @(negedge clk);
        prog_TVALID = 1'b0;
        prog_TLAST  = 1'b0;
    endtask

    // Reference model + driver for a well-formed section. Expected writes
    // come straight from the payload layout: item i lives in word i/4, byte
    // i%4 (byte sections) or word i (immediates), at address start+i.
    // early >= 0 puts TLAST on that word and ends the section there.
    task automatic send_section(input int kind, input int start, input int n,
                                input int early, input int gap_mode);
        int nwords;
        int gap;
        logic [31:0] w;
        send(hdr(kind, start, n), 1'b0, 0);
        nwords = (kind == 1) ? n : (n + 3) / 4;
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            if (kind == 1) begin
                push_exp(1, (start + i) % 16, w);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (4 * i + k < n) begin
                        push_exp(kind, (kind == 0) ? (start + 4 * i + k) % 1024 : (start + 4 * i + k) % 16,
                                 {24'h0, w[8 * k +: 8]});
                    end
                end
            end
            gap = (gap_mode == 0) ? 0 : ((gap_mode == 1) ? 1 : int'($urandom_range(0, 2)));
            send(w, (i == nwords - 1) || (i == early), gap);
            if (i == early) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tready/strobes/loading/done/err=%b, required 0000000",
                     {prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err});
        end
        n_checks++;
        if ({inst_mem_wr_addr, inst_mem_wr_data, imm_wr_addr, imm_wr_data, jmp_off_wr_addr, jmp_off_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr/data buses not all zero in reset");
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (prog_TREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_tready: got %b before first edge, required 0", prog_TREADY);
        end
        @(negedge clk);
        n_checks++;
        if (prog_TREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_edge_tready: got %b, required 1", prog_TREADY);
        end
    endtask

    task automatic test_inst_wrap();
        obs_q.delete(); exp_q.delete(); tready_low = 0;
        send(hdr(0, 'h3FE, 6), 1'b0, 0);
        send(32'h44332211, 1'b0, 0);
        send(32'h00006655, 1'b1, 0);
        repeat (6) @(negedge clk);
        push_exp(0, 'h3FE, 32'h11); push_exp(0, 'h3FF, 32'h22);
        push_exp(0, 'h000, 32'h33); push_exp(0, 'h001, 32'h44);
        push_exp(0, 'h002, 32'h55); push_exp(0, 'h003, 32'h66);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL inst_wrap_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr ||
                obs_q[i].data !== exp_q[i].data || obs_q[i].cyc !== obs_q[0].cyc + i) begin
                n_fail++;
                $display("FAIL inst_wrap_write[%0d]: got kind %0d addr %0h data %0h cyc %0d, required kind %0d addr %0h data %0h cyc %0d",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, obs_q[i].cyc,
                         exp_q[i].kind, exp_q[i].addr, exp_q[i].data, obs_q[0].cyc + i);
            end
        end
        n_checks++;
        if (tready_low !== 4) begin
            n_fail++;
            $display("FAIL inst_wrap_tready_low: got %0d low cycles, required 4", tready_low);
        end
        n_checks++;
        if (loading !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL inst_wrap_status: loading=%b err=%b, required loading=1 err=0", loading, err);
        end
    endtask

    task automatic test_imm_end();
        obs_q.delete(); exp_q.delete();
        send(hdr(1, 14, 2), 1'b0, 0);
        send(32'hDEADBEEF, 1'b0, 0);
        send(32'h00000001, 1'b1, 0);
        repeat (3) @(negedge clk);
        push_exp(1, 14, 32'hDEADBEEF); push_exp(1, 15, 32'h1);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL imm_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr ||
                obs_q[i].data !== exp_q[i].data || obs_q[i].cyc !== obs_q[0].cyc + i) begin
                n_fail++;
                $display("FAIL imm_write[%0d]: got kind %0d addr %0d data %0h, required kind %0d addr %0d data %0h back-to-back",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
            end
        end
        done_cnt = 0;
        send(hdr(3, 0, 0), 1'b0, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt !== 1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL end_done: got %0d done pulses loading=%b, required 1 pulse loading=0", done_cnt, loading);
        end
    endtask

    task automatic test_jmp_range();
        obs_q.delete(); exp_q.delete();
        send(hdr(2, 15, 2), 1'b0, 0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_range_err: got %b, required 1", err);
        end
        send($urandom, 1'b0, 0);
        send($urandom, 1'b0, 1);
        send($urandom, 1'b1, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 0 || err !== 1'b1 || loading !== 1'b1) begin
            n_fail++;
            $display("FAIL jmp_drain: got %0d writes err=%b loading=%b, required 0 writes err=1 loading=1",
                     obs_q.size(), err, loading);
        end
        send(hdr(0, 5, 1), 1'b0, 0);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL jmp_err_clear: got %b after next header, required 0", err);
        end
        send(32'h000000A7, 1'b1, 0);
        repeat (3) @(negedge clk);
        push_exp(0, 5, 32'hA7);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL jmp_after_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL jmp_after_write[%0d]: got kind %0d addr %0h data %0h, required kind %0d addr %0h data %0h",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_early_tlast();
        obs_q.delete(); exp_q.delete();
        send_section(0, 16, 8, 0, 0);
        repeat (6) @(negedge clk);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_tlast_err: got %b, required 1", err);
        end
        send_section(1, 3, 1, -1, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL early_tlast_next_hdr: err=%b, required 0", err);
        end
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL early_tlast_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL early_tlast_write[%0d]: got kind %0d addr %0h data %0h, required kind %0d addr %0h data %0h",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_tvalid_toggle();
        obs_q.delete(); exp_q.delete();
        send_section(1, 4, 4, -1, 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL tvalid_toggle_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL tvalid_toggle_write[%0d]: got kind %0d addr %0d data %0h, required kind %0d addr %0d data %0h",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_unpack();
        logic [31:0] w;
        obs_q.delete(); exp_q.delete();
        w = $urandom;
        send(hdr(0, 100, 8), 1'b0, 0);
        send(w, 1'b0, 0);
        push_exp(0, 100, {24'h0, w[7:0]});
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err} !== 7'b0 ||
            {inst_mem_wr_addr, inst_mem_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_unpack: ctrl=%b inst_addr=%0h inst_data=%0h, required all 0",
                     {prog_TREADY, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en, loading, done, err},
                     inst_mem_wr_addr, inst_mem_wr_data);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (prog_TREADY !== 1'b1 || loading !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release: tready=%b loading=%b, required tready=1 loading=0", prog_TREADY, loading);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== 1 || obs_q[0].addr !== 100 || obs_q[0].data !== exp_q[0].data) begin
            n_fail++;
            $display("FAIL reset_mid_writes: got %0d writes, required exactly byte 0 at addr 100", obs_q.size());
        end
    endtask

    task automatic test_random();
        int kind;
        int start;
        int n;
        obs_q.delete(); exp_q.delete();
        done_cnt = 0;
        for (int s = 0; s < 10; s++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                start = int'($urandom_range(0, 1023));
                n     = int'($urandom_range(1, 12));
            end else begin
                start = int'($urandom_range(0, 15));
                n     = int'($urandom_range(1, 16 - start));
            end
            if ($urandom_range(0, 3) == 0) send(hdr(kind, start, 0), 1'b0, 0);
            send_section(kind, start, n, -1, 2);
        end
        send(hdr(3, 0, 0), 1'b0, 1);
        repeat (6) @(negedge clk);
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d writes, required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL random_write[%0d]: got kind %0d addr %0h data %0h, required kind %0d addr %0h data %0h",
                         i, obs_q[i].kind, obs_q[i].addr, obs_q[i].data, exp_q[i].kind, exp_q[i].addr, exp_q[i].data);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || loading !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL random_end: done pulses %0d loading=%b err=%b, required 1 0 0", done_cnt, loading, err);
        end
    endtask

    initial begin
        test_reset();
        test_inst_wrap();
        test_imm_end();
        test_jmp_range();
        test_early_tlast();
        test_tvalid_toggle();
        test_reset_mid_unpack();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_prog_loader.md
# cpu_prog_loader

Stream-driven program loader for the axis_cpu. It sits directly upstream of the datapath's reprogramming ports. It accepts a 32-bit AXI-Stream of section headers and payload words, and unpacks them into single-entry write strobes for the instruction memory, the immediates table and the jump-offset table. It holds the CPU idle while a program is being loaded and pulses `done` when the load completes.

## Interface
- `CODE_ADDR_WIDTH`, 10, instruction-memory address width; must match the datapath.
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-low reset.
- `prog_TDATA`  in  32  header or payload word.
- `prog_TVALID`  in  1  upstream word valid.
- `prog_TREADY`  out  1  loader accepts the word this cycle.
- `prog_TLAST`  in  1  last word of the upstream packet; used only for error recovery.
- `inst_mem_wr_addr`  out  CODE_ADDR_WIDTH  instruction byte address.
- `inst_mem_wr_data`  out  8  instruction byte.
- `inst_mem_wr_en`  out  1  instruction write strobe.
- `imm_wr_addr`  out  4  immediate-table index.
- `imm_wr_data`  out  32  immediate value.
- `imm_wr_en`  out  1  immediate write strobe.
- `jmp_off_wr_addr`  out  4  jump-table index.
- `jmp_off_wr_data`  out  8  signed jump offset.
- `jmp_off_wr_en`  out  1  jump write strobe.
- `loading`  out  1  high while a program load is in progress; the controller holds the CPU idle while it is high.
- `done`  out  1  one-cycle pulse when an END header is accepted.
- `err`  out  1  sticky format error; cleared by reset or by the next accepted header.

## Operation
- Header word fields:
  - [31:30] type: 00 INST, 01 IMM, 10 JMP, 11 END.
  - [25:16] start address (low CODE_ADDR_WIDTH bits for INST, low 4 bits for IMM/JMP).
  - [15:0] count N: bytes for INST/JMP, words for IMM.
  - [29:26] ignored.
- Payload layout:
  - INST and JMP: ceil(N/4) words, 4 bytes per word, byte k at [8k+7:8k], byte 0 written first.
  - IMM: N words, one per entry.
  - Unused bytes in the final word are discarded.
  - Address increments by 1 per item. INST addresses wrap modulo 2^CODE_ADDR_WIDTH.
- States: HDR, INST_W, UNPACK, IMM_W, JMP_W, DRAIN.
- HDR: TREADY=1. On header accept:
  - N=0: stay in HDR (header-only section).
  - INST: go to INST_W.
  - IMM: go to IMM_W.
  - JMP: go to JMP_W.
  - END: pulse `done`, clear `loading`, stay in HDR.
  - Any non-END header sets `loading` and clears `err`.
- INST_W / JMP_W: TREADY=1. On accept:
  - Write byte 0.
  - If remaining items > 1, go to UNPACK, which emits up to 3 further bytes from the latched word, one per cycle, with TREADY=0.
  - Return to the word state while items remain, else to HDR.
- IMM_W: TREADY=1. One write per accepted word. Return to HDR after N writes.
- Range check, made at header accept: IMM/JMP start+N > 16 sets `err` and enters DRAIN. INST has no range check.
- Early TLAST: a payload word with TLAST=1 that is not the section's final word sets `err`. Its items are still written, then the loader returns to HDR.
- A header accepted with TLAST=1 needs no special handling; TLAST on headers is ignored.
- DRAIN: TREADY=1; discards words up to and including the one with TLAST=1, then returns to HDR. No write strobes are issued.
- `loading` stays high across the error paths until an END header is accepted.

## Timing
- All outputs are registered.
- Reset values: every output 0, including TREADY. TREADY rises on the first clock edge after reset release.
- Latency: for a word accepted at edge t, the first write strobe is high in cycle t+1 with its addr/data valid alongside. UNPACK bytes follow in t+2, t+3, t+4.
- Throughput:
  - INST/JMP: 1 byte/cycle sustained; a 4-byte word occupies 4 cycles, 1 with TREADY high and 3 with TREADY low.
  - IMM: 1 word/cycle.
- At most one write strobe is high in any cycle; the three strobes are mutually exclusive.
- `done` is high in cycle t+1 after END is accepted at edge t. `loading` falls in the same cycle.
- TVALID low stalls a word state with no strobes. UNPACK does not depend on TVALID.
- Reset asserted mid-section: the FSM returns immediately to HDR with all outputs 0. Entries already written stay in the memories.

## Test plan
- INST header start=0x3FE, N=6, then words 0x44332211 and 0x00006655:
  - Strobes in consecutive cycles: addr 0x3FE=0x11, 0x3FF=0x22, 0x000=0x33, 0x001=0x44 (wrap), 0x002=0x55, 0x003=0x66.
  - TREADY low for 3 cycles after word 1 and for 1 cycle after word 2.
- IMM header start=14, N=2, words 0xDEADBEEF then 0x1:
  - imm writes to 14 and 15 in back-to-back cycles.
  - Then an END header: `done` pulses once and `loading` falls.
- JMP header start=15, N=2:
  - `err`=1, no strobes.
  - 3 words discarded, the last with TLAST=1.
  - The next INST header is accepted and clears `err`.
- INST N=8 with TLAST on the first payload word:
  - 4 bytes written, then `err`=1.
  - The next word is treated as a header.
- TVALID toggled every other cycle during an IMM N=4 load:
  - Exactly 4 writes, in order, with no duplicates.
  - Then reset asserted mid-INST UNPACK: all outputs 0 immediately, and TREADY=1 one edge after release.
